top_cnt6: RTL and testbench
===========================

Name: top_cnt6

Overview:
- Modulo-60 counter (0..59, 6-bit) advanced by a programmable clock-divider tick.
- Used as a seconds/minutes counter: `num` sets the clock cycles per count step, e.g. 100000000 at 100 MHz gives 1 s.
- With `num` = 1 the divider is transparent and the block is a plain free-running mod-60 counter (the standalone "cnt6" behaviour).
- Sits directly behind the board clock; `out` drives display/decoder logic.

Parameters:
- CNT_MAX, 59: terminal value of the output counter; `out` wraps from CNT_MAX to 0. Must fit in 6 bits.
- DIV_W, 32: width of the divider counter and of the `num` port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset; asserted when 1, sampled on the rising edge of `clk`.
- num  input  DIV_W  clock cycles per count step; may change at any time.
- out  output  6  current count, 0..CNT_MAX, registered.

Behaviour:
- Single clock domain. No asynchronous logic. All registers update only on the rising edge of `clk`.
- Reset (`rst_n` = 1 at an edge):
  - `div_cnt` <= 0 and `out` <= 0.
  - Reset overrides all other activity, including a tick due on that edge.
  - Reset asserted mid-operation clears state on the next edge, regardless of the current count.
- Divider:
  - Internal `div_cnt` is DIV_W bits wide.
  - Effective terminal value: `term` = `num` − 1 when `num` ≥ 1; `term` = 0 when `num` = 0, so `num` = 0 behaves as `num` = 1.
  - `tick` is combinational: `tick` = (`div_cnt` >= `term`).
  - On a non-reset edge: if `tick`, then `div_cnt` <= 0; otherwise `div_cnt` <= `div_cnt` + 1.
  - The >= compare ensures that lowering `num` below the current `div_cnt` forces a wrap on the next edge, with no 2^32 runaway.
- Output counter, on a non-reset edge with `tick` = 1:
  - If `out` == CNT_MAX, then `out` <= 0.
  - Otherwise `out` <= `out` + 1.
  - Without `tick`, `out` holds.
- Latency: after reset release, the first increment (`out` 0->1) happens on the N-th rising edge with `rst_n` = 0, where N = max(`num`, 1). Subsequent increments occur every N edges.
- Wrap: `out` sequence is 0,1,...,59,0,... Values 60..63 are never produced.
- Period of `out`: 60·N cycles.
- Changing `num`:
  - Takes effect on the current divider period.
  - If the new `term` exceeds `div_cnt`, counting continues up to the new `term`.
  - If the new `term` is ≤ `div_cnt`, `tick` fires on the next edge.
- Implementation split:
  - Divider submodule, with a `tick` output.
  - mod-CNT_MAX+1 counter submodule, with an enable input.
  - A top wrapper connecting them.

Test Plan:
- `num` = 1, reset for 1 cycle then release -> `out` = 1 after the 1st edge, increments every cycle, reads 59 after 59 edges, reads 0 after 60 edges, then repeats.
- `num` = 5 -> `out` stays 0 for edges 1–4, becomes 1 at edge 5 and 2 at edge 10; the 0 to 0 wrap takes 300 cycles.
- `num` = 0 -> identical waveform to `num` = 1.
- Reset asserted while `out` = 37 and `div_cnt` is mid-count -> on the next edge `out` = 0 and `div_cnt` = 0. Counting restarts with the full N-cycle latency after release.
- `num` = 100, run to `div_cnt` = 50, then set `num` = 10 -> `tick` fires on the next edge (`out` += 1), after which the period is 10 cycles.
- `num` = 100000000 at a 10 ns clock -> check `div_cnt` wraps and `out` increments exactly at cycle 100000000 (1 s). A shortened run may force `div_cnt` near the terminal value via hierarchical deposit.

Source files
------------

// File: rtl/top_cnt6_if.sv
// Count-step setting and count output of top_cnt6, bundled as one port.
// The slave side is the counter; the master side is whoever programs the rate and reads the count.
interface top_cnt6_if #(
    parameter int DIV_W = 32
);
    logic [DIV_W-1:0] num;
    logic [5:0]       out;

    modport master (
        output num,
        input  out
    );

    modport slave (
        input  num,
        output out
    );
endinterface

// File: rtl/top_cnt6.sv
// Modulo-(CNT_MAX+1) counter stepped by a programmable clock divider.
// With num = 1 (or 0) it counts once per clock; a larger num slows it to one step per num cycles.
module cnt6_div #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] i_num,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_term;

    // num = 0 is treated like num = 1. The >= compare means lowering num below the
    // current count wraps on the next edge, instead of running on to 2^DIV_W.
    assign w_term = (i_num == '0) ? '0 : i_num - DIV_W'(1);
    assign o_tick = (r_div_cnt >= w_term);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_div_cnt <= '0;
        end else if (o_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end
endmodule

module cnt6_mod #(
    parameter int CNT_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic [5:0] o_cnt
);
    logic [5:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == 6'(CNT_MAX)) ? 6'd0 : r_cnt + 6'd1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

module top_cnt6 #(
    parameter int CNT_MAX = 59,
    parameter int DIV_W   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    top_cnt6_if.slave  bus
);
    logic w_tick;

    cnt6_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_num  (bus.num),
        .o_tick (w_tick)
    );

    cnt6_mod #(
        .CNT_MAX (CNT_MAX)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_tick),
        .o_cnt (bus.out)
    );
endmodule

// File: tb/tb_top_cnt6.sv
// Self-checking bench for top_cnt6: a per-edge reference model pushes the expected count
// into a scoreboard queue, and each scenario pops and compares after every edge.
module tb_top_cnt6;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    top_cnt6_if #(.DIV_W(32)) bus ();

    top_cnt6 #(
        .CNT_MAX (59),
        .DIV_W   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_div = '0;
    logic [5:0]  m_out = '0;
    logic [5:0]  sb[$];
    logic [5:0]  exp_v;

    // One rising edge: update the reference model from the inputs in force, push its count, then clock.
    task automatic cycle();
        logic [31:0] term;
        term = (bus.num == 32'd0) ? 32'd0 : bus.num - 32'd1;
        if (rst_n) begin
            m_div = '0;
            m_out = '0;
        end else if (m_div >= term) begin
            m_div = '0;
            m_out = (m_out == 6'd59) ? 6'd0 : m_out + 6'd1;
        end else begin
            m_div = m_div + 32'd1;
        end
        sb.push_back(m_out);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.num = 32'd1;
        rst_n = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            cycle();
            exp_v = sb.pop_front();
            n_tests++;
            if (bus.out !== 6'd0 || bus.out !== exp_v)
                begin n_fail++; $display("FAIL reset_out cyc=%0d out=%0d expected=0", i, bus.out); end
            else $display("[TB] reset_out cyc=%0d out=%0d ok", i, bus.out);
        end
        n_tests++;
        if (dut.u_div.r_div_cnt !== 32'd0)
            begin n_fail++; $display("FAIL reset_div div_cnt=%0d expected=0", dut.u_div.r_div_cnt); end
        else $display("[TB] reset_div div_cnt=0 ok");
        rst_n = 1'b0;
    endtask

    task automatic test_num1();
        bus.num = 32'd1;
        rst_n = 1'b1; cycle(); void'(sb.pop_front()); rst_n = 1'b0;
        for (int i = 1; i <= 125; i++) begin
            cycle();
            exp_v = sb.pop_front();
            n_tests++;
            if (bus.out !== exp_v ||
                (i == 1 && bus.out !== 6'd1) || (i == 59 && bus.out !== 6'd59) ||
                (i == 60 && bus.out !== 6'd0))
                begin n_fail++; $display("FAIL num1 cyc=%0d out=%0d expected=%0d", i, bus.out, exp_v); end
            else $display("[TB] num1 cyc=%0d out=%0d ok", i, bus.out);
        end
    endtask

    task automatic test_num5();
        bus.num = 32'd5;
        rst_n = 1'b1; cycle(); void'(sb.pop_front()); rst_n = 1'b0;
        for (int i = 1; i <= 305; i++) begin
            cycle();
            exp_v = sb.pop_front();
            n_tests++;
            if (bus.out !== exp_v || (i <= 4 && bus.out !== 6'd0) ||
                (i == 5 && bus.out !== 6'd1) || (i == 10 && bus.out !== 6'd2) ||
                (i == 299 && bus.out !== 6'd59) || (i == 300 && bus.out !== 6'd0))
                begin n_fail++; $display("FAIL num5 cyc=%0d out=%0d expected=%0d", i, bus.out, exp_v); end
            else $display("[TB] num5 cyc=%0d out=%0d ok", i, bus.out);
        end
    endtask

    task automatic test_num0();
        bus.num = 32'd0;
        rst_n = 1'b1; cycle(); void'(sb.pop_front()); rst_n = 1'b0;
        for (int i = 1; i <= 125; i++) begin
            cycle();
            exp_v = sb.pop_front();
            n_tests++;
            if (bus.out !== exp_v || bus.out !== 6'(i % 60))
                begin n_fail++; $display("FAIL num0 cyc=%0d out=%0d expected=%0d", i, bus.out, i % 60); end
            else $display("[TB] num0 cyc=%0d out=%0d ok", i, bus.out);
        end
    endtask

    task automatic test_reset_mid();
        bus.num = 32'd3;
        rst_n = 1'b1; cycle(); void'(sb.pop_front()); rst_n = 1'b0;
        for (int i = 1; i <= 112; i++) begin
            cycle();
            exp_v = sb.pop_front();
            n_tests++;
            if (bus.out !== exp_v)
                begin n_fail++; $display("FAIL rmid_run cyc=%0d out=%0d expected=%0d", i, bus.out, exp_v); end
            else $display("[TB] rmid_run cyc=%0d out=%0d ok", i, bus.out);
        end
        n_tests++;
        if (bus.out !== 6'd37 || dut.u_div.r_div_cnt !== 32'd1)
            begin n_fail++; $display("FAIL rmid_pre out=%0d div=%0d expected out=37 div=1", bus.out, dut.u_div.r_div_cnt); end
        else $display("[TB] rmid_pre out=37 div=1 ok");
        rst_n = 1'b1;
        cycle();
        exp_v = sb.pop_front();
        n_tests++;
        if (bus.out !== exp_v || bus.out !== 6'd0 || dut.u_div.r_div_cnt !== 32'd0)
            begin n_fail++; $display("FAIL rmid_clear out=%0d div=%0d expected out=0 div=0", bus.out, dut.u_div.r_div_cnt); end
        else $display("[TB] rmid_clear out=0 div=0 ok");
        rst_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            exp_v = sb.pop_front();
            n_tests++;
            if (bus.out !== exp_v || (i < 3 && bus.out !== 6'd0) || (i == 3 && bus.out !== 6'd1))
                begin n_fail++; $display("FAIL rmid_restart cyc=%0d out=%0d expected=%0d", i, bus.out, exp_v); end
            else $display("[TB] rmid_restart cyc=%0d out=%0d ok", i, bus.out);
        end
    endtask

    task automatic test_num_change();
        bus.num = 32'd100;
        rst_n = 1'b1; cycle(); void'(sb.pop_front()); rst_n = 1'b0;
        repeat (50) begin cycle(); void'(sb.pop_front()); end
        n_tests++;
        if (bus.out !== 6'd0 || dut.u_div.r_div_cnt !== 32'd50)
            begin n_fail++; $display("FAIL chg_pre out=%0d div=%0d expected out=0 div=50", bus.out, dut.u_div.r_div_cnt); end
        else $display("[TB] chg_pre out=0 div=50 ok");
        bus.num = 32'd10;
        for (int i = 0; i <= 20; i++) begin
            cycle();
            exp_v = sb.pop_front();
            n_tests++;
            if (bus.out !== exp_v || (i == 0 && bus.out !== 6'd1) ||
                (i == 9 && bus.out !== 6'd1) || (i == 10 && bus.out !== 6'd2) || (i == 20 && bus.out !== 6'd3))
                begin n_fail++; $display("FAIL chg cyc=%0d out=%0d expected=%0d", i, bus.out, exp_v); end
            else $display("[TB] chg cyc=%0d out=%0d ok", i, bus.out);
        end
    endtask

    task automatic test_large_num();
        bus.num = 32'd100000000;
        rst_n = 1'b1; cycle(); void'(sb.pop_front()); rst_n = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            cycle();
            exp_v = sb.pop_front();
            n_tests++;
            if (bus.out !== exp_v || bus.out !== 6'd0)
                begin n_fail++; $display("FAIL large cyc=%0d out=%0d expected=0", i, bus.out); end
            else $display("[TB] large cyc=%0d out=%0d ok", i, bus.out);
        end
        n_tests++;
        if (dut.u_div.r_div_cnt !== 32'd200)
            begin n_fail++; $display("FAIL large_div div=%0d expected=200", dut.u_div.r_div_cnt); end
        else $display("[TB] large_div div=200 ok");
        bus.num = 32'd10;
        cycle();
        exp_v = sb.pop_front();
        n_tests++;
        if (bus.out !== exp_v || bus.out !== 6'd1 || dut.u_div.r_div_cnt !== 32'd0)
            begin n_fail++; $display("FAIL large_drop out=%0d div=%0d expected out=1 div=0", bus.out, dut.u_div.r_div_cnt); end
        else $display("[TB] large_drop out=1 div=0 ok");
    endtask

    initial begin
        bus.num = 32'd1;
        #2;
        test_reset();
        test_num1();
        test_num5();
        test_num0();
        test_reset_mid();
        test_num_change();
        test_large_num();
        n_tests++;
        if (sb.size() != 0)
            begin n_fail++; $display("FAIL sb_drain left=%0d expected=0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
